// File: rtl/tff_count_ctrl_pkg.sv
// Shared types for the T flip-flop count controller: FSM states and run-mode encodings.
package tff_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_GRAY = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

endpackage

// File: rtl/tff_count_ctrl_cell.sv
// Single T flip-flop cell of the counter bank; toggles on clk when t is high.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= 1'b0;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/tff_count_ctrl.sv
// Sequencer driving a bank of WIDTH T flip-flops through up/down/Gray/hold runs.
// Optional macro TFF_GRAY_MODE_EN builds the Gray-code stepping; otherwise mode 10 counts up.
module tff_count_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t_vec,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [1:0]       mode_l;
  logic [WIDTH-1:0] limit_l;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] next_q;
  logic             terminal;

`ifdef TFF_GRAY_MODE_EN
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction
`endif

  always_comb begin
    step_q = q;
    case (mode_l)
      MODE_UP:   step_q = q + ONE;
      MODE_DOWN: step_q = q - ONE;
`ifdef TFF_GRAY_MODE_EN
      MODE_GRAY: step_q = bin2gray(gray2bin(q) + ONE);
`else
      MODE_GRAY: step_q = q + ONE;
`endif
      default:   step_q = q;
    endcase
  end

  // Hold mode never moves q, so it runs until stopped rather than ending on the limit.
  assign terminal = (state == RUN) && !stop && (mode_l != MODE_HOLD) && (step_q == limit_l);

  always_comb begin
    next_q = q;
    case (state)
      IDLE:    if (load) next_q = load_val;
      RUN:     if (!stop) next_q = step_q;
      default: next_q = q;
    endcase
  end

  assign t_vec = rst_n ? (q ^ next_q) : '0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t_vec[i]),
      .q     (q[i])
    );
  end

  // Load takes priority over start in IDLE; stop takes priority over terminal in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_l  <= MODE_UP;
      limit_l <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!load && start) begin
            state   <= RUN;
            busy    <= 1'b1;
            mode_l  <= mode;
            limit_l <= limit;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (terminal) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Randomized and directed checks of tff_count_ctrl (WIDTH=4) against a sequence-level model.
module tb_tff_count_ctrl;

  localparam int WIDTH = 4;
  localparam int MODN  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [1:0]       mode = 2'b00;
  logic [WIDTH-1:0] limit = '0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t_vec;
  logic             busy;
  logic             done;

  int total = 0;
  int bad = 0;

  // Model: phase 0 idle, 1 running, 2 done pulse.
  int mq = 0;
  int mphase = 0;
  int mmode = 0;
  int mlim = 0;

  tff_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .limit    (limit),
    .q        (q),
    .t_vec    (t_vec),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Next element of the selected sequence; Gray walks the reflected code by position.
  function automatic int seq_next(input int md, input int cur);
    int idx;
    int nxt;
    idx = 0;
    case (md)
      0: return (cur + 1) % MODN;
      1: return (cur + MODN - 1) % MODN;
      2: begin
`ifdef TFF_GRAY_MODE_EN
        for (int i = 0; i < MODN; i++)
          if ((i ^ (i >> 1)) == cur) idx = i;
        nxt = (idx + 1) % MODN;
        return nxt ^ (nxt >> 1);
`else
        nxt = idx;
        return (cur + 1) % MODN + nxt;
`endif
      end
      default: return cur;
    endcase
  endfunction

  task automatic apply_stimulus(input logic ld, input logic st, input logic sp,
                                input int lv, input int md, input int lm);
    int nq;
    int nphase;
    int s;
    @(negedge clk);
    load     = ld;
    start    = st;
    stop     = sp;
    load_val = lv[WIDTH-1:0];
    mode     = md[1:0];
    limit    = lm[WIDTH-1:0];
    nq = mq;
    nphase = mphase;
    case (mphase)
      0: begin
        if (ld) nq = lv % MODN;
        else if (st) begin
          nphase = 1;
          mmode = md % 4;
          mlim = lm % MODN;
        end
      end
      1: begin
        if (sp) nphase = 0;
        else begin
          s = seq_next(mmode, mq);
          nq = s;
          if (mmode != 3 && s == mlim) nphase = 2;
        end
      end
      default: nphase = 0;
    endcase
    #1;
    check_output("t_vec", 32'(t_vec), 32'(mq ^ nq));
    @(posedge clk);
    #1;
    mq = nq;
    mphase = nphase;
    check_output("q", 32'(q), 32'(mq));
    check_output("busy", 32'(busy), 32'(mphase == 1));
    check_output("done", 32'(done), 32'(mphase == 2));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    #3;
    check_output("rst_q", 32'(q), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_tvec", 32'(t_vec), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset while running at q=5.
    apply_stimulus(1'b1, 1'b0, 1'b0, 2, 0, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0, 15);
    idle_cycles(3);
    check_output("t1_q_before", 32'(q), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t1_q", 32'(q), 32'd0);
    check_output("t1_busy", 32'(busy), 32'd0);
    check_output("t1_done", 32'(done), 32'd0);
    mq = 0; mphase = 0; mmode = 0; mlim = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Up count 3 -> 7 with done on q==7.
    apply_stimulus(1'b1, 1'b0, 1'b0, 3, 0, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0, 7);
    idle_cycles(4);
    check_output("t2_q", 32'(q), 32'd7);
    check_output("t2_done", 32'(done), 32'd1);
    idle_cycles(1);

    // Down count wrapping 0 -> 15 -> 14.
    apply_stimulus(1'b1, 1'b0, 1'b0, 1, 0, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 0, 1, 14);
    idle_cycles(1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    check_output("t3_q", 32'(q), 32'd15);
    idle_cycles(1);
    check_output("t3_done", 32'(done), 32'd1);
    idle_cycles(1);

    // Stop at q=5 holds q.
    apply_stimulus(1'b1, 1'b0, 1'b0, 2, 0, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 0, 0, 9);
    idle_cycles(3);
    apply_stimulus(1'b0, 1'b0, 1'b1, 0, 0, 0);
    check_output("t4_q", 32'(q), 32'd5);
    check_output("t4_busy", 32'(busy), 32'd0);
    idle_cycles(3);

    // Load and start together: load wins.
    apply_stimulus(1'b1, 1'b1, 1'b0, 9, 0, 3);
    check_output("t5_q", 32'(q), 32'd9);
    check_output("t5_busy", 32'(busy), 32'd0);
    idle_cycles(2);

    // Mode 10 from 0 to limit 0110.
    apply_stimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 0, 2, 6);
    for (int i = 0; i < 20 && mphase != 0; i++) idle_cycles(1);
    check_output("t6_end_q", 32'(q), 32'd6);

    // Random traffic including mid-run load/start/mode/limit changes.
    for (int i = 0; i < 600; i++) begin
      apply_stimulus(($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
